// File: rtl/multi_device_memory_controller_pkg.sv
// Shared definitions for the multi-device memory controller: FSM encoding and
// helpers that pull one device's field out of a packed timing parameter.
package multi_device_memory_controller_pkg;

  typedef enum logic [2:0] {
    S_INIT,
    S_RESET,
    S_RELEASE,
    S_IDLE,
    S_DEAC,
    S_READ,
    S_WRITE,
    S_REC
  } state_t;

  // Widest packed timing vector supported (8 devices x 32-bit fields).
  localparam int PACK_W = 256;

  function automatic logic [31:0] cyc_field(input logic [PACK_W-1:0] vec,
                                            input int idx,
                                            input int w);
    return 32'((vec >> (idx * w)) & ((PACK_W'(1) << w) - PACK_W'(1)));
  endfunction

endpackage

// File: rtl/multi_device_memory_controller_rr_arbiter.sv
// Combinational round-robin picker: search starts just after the last owner
// and wraps around so the last owner has the lowest priority.
module multi_device_memory_controller_rr_arbiter #(
  parameter int NUM_DEV = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_DEV-1:0] i_req,
  input  logic [IDX_W-1:0]   i_last,
  output logic [NUM_DEV-1:0] o_grant,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_valid
);

  int w_cand;

  always_comb begin
    o_grant = '0;
    o_idx   = i_last;
    o_valid = 1'b0;
    w_cand  = 0;
    for (int k = 1; k <= NUM_DEV; k++) begin
      w_cand = (int'(i_last) + k) % NUM_DEV;
      if (!o_valid && i_req[w_cand]) begin
        o_valid         = 1'b1;
        o_grant[w_cand] = 1'b1;
        o_idx           = IDX_W'(w_cand);
      end
    end
  end

endmodule

// File: rtl/multi_device_memory_controller.sv
// Shares one asynchronous parallel memory bus between NUM_DEV client ports,
// each bound to its own chip select, with round-robin arbitration.
module multi_device_memory_controller
  import multi_device_memory_controller_pkg::*;
#(
  parameter int                         NUM_DEV     = 2,
  parameter int                         ADDR_W      = 23,
  parameter int                         DATA_W      = 16,
  parameter int                         CYC_W       = 11,
  parameter logic [NUM_DEV*CYC_W-1:0]   RD_CYC      = {11'd4, 11'd4},
  parameter logic [NUM_DEV*CYC_W-1:0]   PG_CYC      = {11'd4, 11'd1},
  parameter logic [NUM_DEV*CYC_W-1:0]   WR_CYC      = {11'd4, 11'd3},
  parameter logic [NUM_DEV*CYC_W-1:0]   REC_CYC     = {11'd0, 11'd0},
  parameter logic [NUM_DEV*CYC_W-1:0]   DEAC_CYC    = {11'd0, 11'd1},
  parameter logic [NUM_DEV-1:0]         PAGE_MASK   = 2'b01,
  parameter int                         PAGE_LSB    = 2,
  parameter logic [NUM_DEV-1:0]         STS_MASK    = 2'b01,
  parameter logic [CYC_W-1:0]           RESET_CYC   = 11'd1250,
  parameter logic [CYC_W-1:0]           RELEASE_CYC = 11'd11
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_DEV*ADDR_W-1:0]   p_address,
  input  logic [NUM_DEV*DATA_W-1:0]   p_to_mem,
  output logic [NUM_DEV*DATA_W-1:0]   p_from_mem,
  input  logic [NUM_DEV-1:0]          p_req,
  input  logic [NUM_DEV-1:0]          p_wren,
  output logic [NUM_DEV-1:0]          p_ready,
  input  logic [NUM_DEV-1:0]          dev_sts,
  output logic [ADDR_W-1:0]           shared_a,
  inout  wire  [DATA_W-1:0]           shared_d,
  output logic                        shared_oe_n,
  output logic                        shared_we_n,
  output logic [NUM_DEV-1:0]          dev_ce_n,
  output logic                        dev_reset_n,
  output logic                        bus_adv_n
);

  localparam int IDX_W = (NUM_DEV > 1) ? $clog2(NUM_DEV) : 1;
  localparam int TAG_W = ADDR_W - PAGE_LSB;

  logic [CYC_W-1:0] w_rd_cyc   [NUM_DEV];
  logic [CYC_W-1:0] w_pg_cyc   [NUM_DEV];
  logic [CYC_W-1:0] w_wr_cyc   [NUM_DEV];
  logic [CYC_W-1:0] w_rec_cyc  [NUM_DEV];
  logic [CYC_W-1:0] w_deac_cyc [NUM_DEV];

  for (genvar g = 0; g < NUM_DEV; g++) begin : g_timing
    assign w_rd_cyc[g]   = CYC_W'(cyc_field(PACK_W'(RD_CYC),   g, CYC_W));
    assign w_pg_cyc[g]   = CYC_W'(cyc_field(PACK_W'(PG_CYC),   g, CYC_W));
    assign w_wr_cyc[g]   = CYC_W'(cyc_field(PACK_W'(WR_CYC),   g, CYC_W));
    assign w_rec_cyc[g]  = CYC_W'(cyc_field(PACK_W'(REC_CYC),  g, CYC_W));
    assign w_deac_cyc[g] = CYC_W'(cyc_field(PACK_W'(DEAC_CYC), g, CYC_W));
  end

  state_t                    r_state, w_state_nxt;
  logic [CYC_W-1:0]          r_cnt, w_cnt_nxt;
  logic [IDX_W-1:0]          r_owner, w_owner_nxt;
  logic [NUM_DEV-1:0]        r_req_prev, r_pend, w_pend_nxt, w_pend_clr, w_rise;
  logic [NUM_DEV-1:0]        r_sts_s1, r_sts_s2, w_elig;
  logic [NUM_DEV-1:0]        r_pg_vld, w_pg_vld_nxt;
  logic [TAG_W-1:0]          r_pg_tag [NUM_DEV];
  logic [TAG_W-1:0]          w_pg_tag_nxt [NUM_DEV];
  logic [ADDR_W-1:0]         r_addr, w_addr_nxt;
  logic [DATA_W-1:0]         r_wdata, w_wdata_nxt;
  logic                      r_wren, w_wren_nxt;
  logic                      r_drive, w_drive_nxt;
  logic                      r_oe_n, w_oe_n_nxt;
  logic                      r_we_n, w_we_n_nxt;
  logic                      r_adv_n, w_adv_n_nxt;
  logic                      r_reset_n, w_reset_n_nxt;
  logic [NUM_DEV-1:0]        r_ce_n, w_ce_n_nxt;
  logic [NUM_DEV-1:0]        r_ready, w_ready_nxt;
  logic [NUM_DEV*DATA_W-1:0] r_from_mem, w_from_mem_nxt;

  logic                      w_launch, w_hit, w_l_wren;
  logic [ADDR_W-1:0]         w_l_addr;
  logic [DATA_W-1:0]         w_l_data;

  logic [NUM_DEV-1:0]        w_grant;
  logic [IDX_W-1:0]          w_win;
  logic                      w_win_vld;

  assign w_rise     = p_req & ~r_req_prev;
  assign w_elig     = r_pend & (~STS_MASK | r_sts_s2);
  assign w_pend_nxt = (r_pend & ~w_pend_clr) | w_rise;

  multi_device_memory_controller_rr_arbiter #(
    .NUM_DEV (NUM_DEV),
    .IDX_W   (IDX_W)
  ) u_arb (
    .i_req   (w_elig),
    .i_last  (r_owner),
    .o_grant (w_grant),
    .o_idx   (w_win),
    .o_valid (w_win_vld)
  );

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_owner_nxt    = r_owner;
    w_pend_clr     = '0;
    w_pg_vld_nxt   = r_pg_vld;
    w_pg_tag_nxt   = r_pg_tag;
    w_addr_nxt     = r_addr;
    w_wdata_nxt    = r_wdata;
    w_wren_nxt     = r_wren;
    w_drive_nxt    = r_drive;
    w_oe_n_nxt     = r_oe_n;
    w_we_n_nxt     = r_we_n;
    w_adv_n_nxt    = r_adv_n;
    w_reset_n_nxt  = r_reset_n;
    w_ce_n_nxt     = r_ce_n;
    w_ready_nxt    = '0;
    w_from_mem_nxt = r_from_mem;
    w_launch       = 1'b0;
    w_hit          = 1'b0;
    w_l_addr       = r_addr;
    w_l_data       = r_wdata;
    w_l_wren       = r_wren;

    case (r_state)
      S_INIT: begin
        w_oe_n_nxt  = 1'b1;
        w_we_n_nxt  = 1'b1;
        w_adv_n_nxt = 1'b1;
        w_cnt_nxt   = RESET_CYC;
        w_state_nxt = S_RESET;
      end
      S_RESET: begin
        if (r_cnt == '0) begin
          w_reset_n_nxt = 1'b1;
          w_cnt_nxt     = RELEASE_CYC;
          w_state_nxt   = S_RELEASE;
        end else begin
          w_cnt_nxt = r_cnt - CYC_W'(1);
        end
      end
      S_RELEASE: begin
        if (r_cnt == '0) w_state_nxt = S_IDLE;
        else             w_cnt_nxt   = r_cnt - CYC_W'(1);
      end
      S_IDLE: begin
        if (w_win_vld) begin
          w_pend_clr  = w_grant;
          w_owner_nxt = w_win;
          w_l_addr    = p_address[int'(w_win)*ADDR_W +: ADDR_W];
          w_l_data    = p_to_mem[int'(w_win)*DATA_W +: DATA_W];
          w_l_wren    = p_wren[w_win];
          if (w_win == r_owner) begin
            w_launch = 1'b1;
          end else begin
            // Old device is deselected first; its open page is no longer valid.
            w_ce_n_nxt[r_owner]   = 1'b1;
            w_pg_vld_nxt[r_owner] = 1'b0;
            w_cnt_nxt             = w_deac_cyc[r_owner];
            w_addr_nxt            = w_l_addr;
            w_wdata_nxt           = w_l_data;
            w_wren_nxt            = w_l_wren;
            w_state_nxt           = S_DEAC;
          end
        end
      end
      S_DEAC: begin
        if (r_cnt == '0) begin
          w_ce_n_nxt          = '1;
          w_ce_n_nxt[r_owner] = 1'b0;
          w_launch            = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - CYC_W'(1);
        end
      end
      S_READ: begin
        if (r_cnt == '0) begin
          w_from_mem_nxt[int'(r_owner)*DATA_W +: DATA_W] = shared_d;
          w_ready_nxt[r_owner] = 1'b1;
          w_oe_n_nxt           = 1'b1;
          w_adv_n_nxt          = 1'b1;
          w_state_nxt          = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - CYC_W'(1);
        end
      end
      S_WRITE: begin
        if (r_cnt == '0) begin
          w_drive_nxt          = 1'b0;
          w_we_n_nxt           = 1'b1;
          w_adv_n_nxt          = 1'b1;
          w_ready_nxt[r_owner] = 1'b1;
          w_cnt_nxt            = w_rec_cyc[r_owner];
          w_state_nxt          = S_REC;
        end else begin
          w_cnt_nxt = r_cnt - CYC_W'(1);
        end
      end
      S_REC: begin
        if (r_cnt == '0) w_state_nxt = S_IDLE;
        else             w_cnt_nxt   = r_cnt - CYC_W'(1);
      end
      default: w_state_nxt = S_INIT;
    endcase

    // The owner register already names the device being accessed here.
    if (w_launch) begin
      w_addr_nxt  = w_l_addr;
      w_wdata_nxt = w_l_data;
      w_wren_nxt  = w_l_wren;
      w_adv_n_nxt = 1'b0;
      w_oe_n_nxt  = w_l_wren;
      w_we_n_nxt  = ~w_l_wren;
      w_drive_nxt = w_l_wren;
      if (w_l_wren) begin
        w_cnt_nxt             = w_wr_cyc[r_owner];
        w_pg_vld_nxt[r_owner] = 1'b0;
        w_state_nxt           = S_WRITE;
      end else begin
        w_hit = PAGE_MASK[r_owner] && r_pg_vld[r_owner] &&
                (w_l_addr[ADDR_W-1:PAGE_LSB] == r_pg_tag[r_owner]);
        w_cnt_nxt             = w_hit ? w_pg_cyc[r_owner] : w_rd_cyc[r_owner];
        w_pg_vld_nxt[r_owner] = 1'b1;
        w_pg_tag_nxt[r_owner] = w_l_addr[ADDR_W-1:PAGE_LSB];
        w_state_nxt           = S_READ;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_INIT;
      r_cnt      <= '0;
      r_owner    <= '0;
      r_req_prev <= '0;
      r_pend     <= '0;
      r_sts_s1   <= '0;
      r_sts_s2   <= '0;
      r_pg_vld   <= '0;
      r_addr     <= '0;
      r_wren     <= 1'b0;
      r_drive    <= 1'b0;
      r_oe_n     <= 1'b0;
      r_we_n     <= 1'b0;
      r_adv_n    <= 1'b0;
      r_reset_n  <= 1'b0;
      r_ce_n     <= ~(NUM_DEV'(1));
      r_ready    <= '0;
      r_from_mem <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_owner    <= w_owner_nxt;
      r_req_prev <= p_req;
      r_pend     <= w_pend_nxt;
      r_sts_s1   <= dev_sts;
      r_sts_s2   <= r_sts_s1;
      r_pg_vld   <= w_pg_vld_nxt;
      r_addr     <= w_addr_nxt;
      r_wren     <= w_wren_nxt;
      r_drive    <= w_drive_nxt;
      r_oe_n     <= w_oe_n_nxt;
      r_we_n     <= w_we_n_nxt;
      r_adv_n    <= w_adv_n_nxt;
      r_reset_n  <= w_reset_n_nxt;
      r_ce_n     <= w_ce_n_nxt;
      r_ready    <= w_ready_nxt;
      r_from_mem <= w_from_mem_nxt;
    end
  end

  // Payload-only registers: qualified by r_drive / r_pg_vld, so no reset needed.
  always_ff @(posedge clk) begin
    r_wdata  <= w_wdata_nxt;
    r_pg_tag <= w_pg_tag_nxt;
  end

  assign shared_a    = r_addr;
  assign shared_d    = r_drive ? r_wdata : {DATA_W{1'bz}};
  assign shared_oe_n = r_oe_n;
  assign shared_we_n = r_we_n;
  assign bus_adv_n   = r_adv_n;
  assign dev_ce_n    = r_ce_n;
  assign dev_reset_n = r_reset_n;
  assign p_ready     = r_ready;
  assign p_from_mem  = r_from_mem;

endmodule

// File: tb/tb_multi_device_memory_controller.sv
// Directed bench for multi_device_memory_controller with a short reset sequence.
module tb_multi_device_memory_controller;

  localparam int NUM_DEV = 2;
  localparam int ADDR_W  = 23;
  localparam int DATA_W  = 16;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [NUM_DEV*ADDR_W-1:0] p_address;
  logic [NUM_DEV*DATA_W-1:0] p_to_mem;
  logic [NUM_DEV*DATA_W-1:0] p_from_mem;
  logic [NUM_DEV-1:0]        p_req, p_wren, p_ready, dev_sts, dev_ce_n;
  logic [ADDR_W-1:0]         shared_a;
  wire  [DATA_W-1:0]         shared_d;
  logic                      shared_oe_n, shared_we_n, dev_reset_n, bus_adv_n;
  logic [DATA_W-1:0]         mem_val;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  int rdy_cnt [NUM_DEV];

  // Memory model: drives the bus whenever output enable is asserted.
  assign shared_d = (!shared_oe_n) ? mem_val : {DATA_W{1'bz}};

  multi_device_memory_controller #(
    .RESET_CYC   (11'd4),
    .RELEASE_CYC (11'd2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .p_address   (p_address),
    .p_to_mem    (p_to_mem),
    .p_from_mem  (p_from_mem),
    .p_req       (p_req),
    .p_wren      (p_wren),
    .p_ready     (p_ready),
    .dev_sts     (dev_sts),
    .shared_a    (shared_a),
    .shared_d    (shared_d),
    .shared_oe_n (shared_oe_n),
    .shared_we_n (shared_we_n),
    .dev_ce_n    (dev_ce_n),
    .dev_reset_n (dev_reset_n),
    .bus_adv_n   (bus_adv_n)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    for (int i = 0; i < NUM_DEV; i++) if (p_ready[i]) rdy_cnt[i]++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  task automatic req(input int p, input logic [ADDR_W-1:0] a, input logic w,
                     input logic [DATA_W-1:0] d);
    p_address[p*ADDR_W +: ADDR_W] = a;
    p_to_mem[p*DATA_W +: DATA_W]  = d;
    p_wren[p] = w;
    p_req[p]  = 1'b1;
    tick();
    p_req[p]  = 1'b0;
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      1:       return shared_we_n;
      2:       return bus_adv_n;
      default: return shared_oe_n;
    endcase
  endfunction

  // Waits for the strobe to go low, then counts the cycles it stays low.
  task automatic measure(input int sel, output int st, output int width,
                         output logic [DATA_W-1:0] d0);
    int b;
    b = 0; st = -1; width = 0; d0 = '0;
    while (sig(sel) !== 1'b0 && b < 200) begin tick(); b++; end
    if (sig(sel) !== 1'b0) begin
      width = -1;
    end else begin
      st = cyc;
      d0 = shared_d;
      while (sig(sel) === 1'b0 && width < 200) begin width++; tick(); end
    end
  endtask

  task automatic count_ce(input logic [NUM_DEV-1:0] val, output int n);
    int b;
    b = 0; n = 0;
    while (dev_ce_n !== val && b < 100) begin tick(); b++; end
    while (dev_ce_n === val && n < 100) begin n++; tick(); end
  endtask

  initial begin
    int st, w, n, r0, r1, b;
    logic [DATA_W-1:0] d0;

    rst = 1'b1; p_req = '0; p_wren = '0; p_address = '0; p_to_mem = '0;
    dev_sts = 2'b11; mem_val = 16'hA5A5;
    repeat (3) tick();
    chk("rst_oe_n", shared_oe_n, 1'b0);
    chk("rst_we_n", shared_we_n, 1'b0);
    chk("rst_adv_n", bus_adv_n, 1'b0);
    chk("rst_ce_n", dev_ce_n, 2'b10);
    chk("rst_dev_reset_n", dev_reset_n, 1'b0);
    chk("rst_ready", p_ready, 2'b00);
    chk("rst_from_mem", p_from_mem, 32'h0);
    chk("rst_addr", shared_a, 23'h0);

    rst = 1'b0; cyc = 0;
    tick();
    chk("init_oe_n", shared_oe_n, 1'b1);
    chk("init_we_n", shared_we_n, 1'b1);
    chk("init_adv_n", bus_adv_n, 1'b1);
    tick();
    // Read request arrives while the device reset sequence is still running.
    p_address[0 +: ADDR_W] = 23'h10; p_wren[0] = 1'b0; p_req[0] = 1'b1;
    tick();
    p_req[0] = 1'b0;
    tick(); tick();
    chk("reset_n_low_c5", dev_reset_n, 1'b0);
    tick();
    chk("reset_n_high_c6", dev_reset_n, 1'b1);
    chk("no_ready_in_init", rdy_cnt[0] + rdy_cnt[1], 0);

    measure(0, st, w, d0);
    chk("rd0_start_cyc", st, 10);
    chk("rd0_oe_width", w, 5);
    tick(); tick();
    chk("rd0_data", p_from_mem[15:0], 16'hA5A5);
    chk("rd0_ready", rdy_cnt[0], 1);
    chk("rd0_addr", shared_a, 23'h10);

    mem_val = 16'h3C01;
    req(0, 23'h11, 1'b0, 16'h0);
    measure(0, st, w, d0);
    chk("pg_hit_oe_width", w, 2);
    tick(); tick();
    chk("pg_hit_data", p_from_mem[15:0], 16'h3C01);

    mem_val = 16'h3C02;
    req(0, 23'h14, 1'b0, 16'h0);
    measure(0, st, w, d0);
    chk("pg_miss_oe_width", w, 5);
    tick(); tick();
    chk("pg_miss_data", p_from_mem[15:0], 16'h3C02);

    req(0, 23'h20, 1'b1, 16'h1234);
    measure(1, st, w, d0);
    chk("wr_we_width", w, 4);
    chk("wr_bus_data", d0, 16'h1234);
    chk("wr_addr", shared_a, 23'h20);
    tick(); tick();
    chk("wr_ready", rdy_cnt[0], 4);

    mem_val = 16'h4008;
    req(0, 23'h20, 1'b0, 16'h0);
    measure(0, st, w, d0);
    chk("rd_after_wr_width", w, 5);
    tick(); tick();
    chk("rd_after_wr_data", p_from_mem[15:0], 16'h4008);

    // Port 0 blocked on status; port 1 must overtake it.
    dev_sts[0] = 1'b0;
    repeat (3) tick();
    mem_val = 16'hBEEF;
    req(0, 23'h21, 1'b0, 16'h0);
    tick(); tick();
    req(1, 23'h100, 1'b0, 16'h0);
    count_ce(2'b11, n);
    chk("deac_dev0_cycles", n, 2);
    chk("ce_dev1_selected", dev_ce_n, 2'b01);
    measure(0, st, w, d0);
    chk("dev1_oe_width", w, 5);
    tick(); tick();
    chk("dev1_data", p_from_mem[31:16], 16'hBEEF);
    chk("port0_data_held", p_from_mem[15:0], 16'h4008);
    chk("dev1_ready", rdy_cnt[1], 1);
    chk("port0_gated", rdy_cnt[0], 5);

    mem_val = 16'h0F0F;
    dev_sts[0] = 1'b1;
    count_ce(2'b11, n);
    chk("deac_dev1_cycles", n, 1);
    chk("ce_dev0_selected", dev_ce_n, 2'b10);
    measure(0, st, w, d0);
    chk("page_lost_on_ce_width", w, 5);
    tick(); tick();
    chk("port0_after_sts_data", p_from_mem[15:0], 16'h0F0F);
    chk("port0_after_sts_ready", rdy_cnt[0], 6);

    // Simultaneous requests with owner 0: port 1 goes first.
    mem_val = 16'h7777;
    r0 = rdy_cnt[0]; r1 = rdy_cnt[1];
    p_address[0 +: ADDR_W] = 23'h40; p_address[ADDR_W +: ADDR_W] = 23'h140;
    p_wren = 2'b00; p_req = 2'b11;
    tick();
    p_req = 2'b00;
    b = 0;
    while (p_ready === 2'b00 && b < 60) begin tick(); b++; end
    chk("sim_first_grant", p_ready, 2'b10);
    tick();
    b = 0;
    while (p_ready === 2'b00 && b < 60) begin tick(); b++; end
    chk("sim_second_grant", p_ready, 2'b01);
    repeat (5) tick();
    chk("sim_port0_once", rdy_cnt[0] - r0, 1);
    chk("sim_port1_once", rdy_cnt[1] - r1, 1);

    // Asynchronous reset in the middle of a read, with port 1 pending.
    mem_val = 16'h0;
    req(0, 23'h30, 1'b0, 16'h0);
    req(1, 23'h150, 1'b0, 16'h0);
    b = 0;
    while (shared_oe_n !== 1'b0 && b < 60) begin tick(); b++; end
    #2 rst = 1'b1;
    #1;
    chk("async_we_n", shared_we_n, 1'b0);
    chk("async_adv_n", bus_adv_n, 1'b0);
    chk("async_dev_reset_n", dev_reset_n, 1'b0);
    chk("async_addr", shared_a, 23'h0);
    chk("async_from_mem", p_from_mem, 32'h0);
    chk("async_ce_n", dev_ce_n, 2'b10);
    r0 = rdy_cnt[0]; r1 = rdy_cnt[1];
    tick();
    rst = 1'b0;
    repeat (25) tick();
    chk("async_port0_lost", rdy_cnt[0] - r0, 0);
    chk("async_port1_lost", rdy_cnt[1] - r1, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
